// File: rtl/line_refill_unit_pkg.sv
// Shared cache definitions: access sizes, refill FSM states and line-geometry helpers.
package line_refill_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  function automatic int offset_bits(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int words_per_line(input int line_bytes);
    return line_bytes / 4;
  endfunction

  localparam int OFFSET_BITS    = offset_bits(16);
  localparam int WORDS_PER_LINE = words_per_line(16);

endpackage

// File: rtl/line_refill_unit_if.sv
// Word-wide read bus between the refill engine (master) and memory (slave).
// Handshake: a request transfers on a rising edge where bus_req_valid and bus_req_ready are
// both high; once raised, bus_req_valid and bus_req_addr hold until that transfer. Responses
// have no back-pressure: bus_rsp_valid qualifies bus_rdata for one cycle, in request order.
interface line_refill_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  bus_req_valid;
  logic                  bus_req_ready;
  logic [ADDR_WIDTH-1:0] bus_req_addr;
  logic                  bus_rsp_valid;
  logic [31:0]           bus_rdata;

  modport master (
    output bus_req_valid,
    output bus_req_addr,
    input  bus_req_ready,
    input  bus_rsp_valid,
    input  bus_rdata
  );

  modport slave (
    input  bus_req_valid,
    input  bus_req_addr,
    output bus_req_ready,
    output bus_rsp_valid,
    output bus_rdata
  );
endinterface

// File: rtl/line_refill_unit.sv
// Instruction-cache line refill: issues word reads for one line and returns it in one pulse.
// Optional REFILL_TIMEOUT_EN aborts a fill that waits TIMEOUT_CYCLES without a response.
module line_refill_unit
  import line_refill_unit_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_BYTES      = 16,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_req,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rvalid,
  output logic [LINE_BYTES*8-1:0] mem_rdata,
  output logic                    refill_err,
  output state_t                  dbg_state,
  line_refill_unit_if.master      bus
);

  localparam int W  = words_per_line(LINE_BYTES);
  localparam int OB = offset_bits(LINE_BYTES);
  localparam int CW = $clog2(W) + 1;
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OB) - 1);

  state_t                state_q, state_n;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] start_base;
  logic [ADDR_WIDTH-1:0] req_addr_n;
  logic [CW-1:0]         issued_q, received_q;
  logic [CW-1:0]         issued_n, received_n;
  logic [W-1:0][31:0]    line_q;
  logic                  accept, rsp_take, start, done, abort, req_valid_n;

  assign start_base = mem_addr & ~OFFSET_MASK;
  assign accept     = (state_q == S_FILL) && bus.bus_req_valid && bus.bus_req_ready;
  assign rsp_take   = (state_q == S_FILL) && bus.bus_rsp_valid && (received_q < CW'(W));

`ifdef REFILL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;

  // Counts idle FILL cycles since the fill started or the last response arrived.
  assign abort = (state_q == S_FILL) && !rsp_take && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || start || rsp_take) tcnt_q <= '0;
    else if (state_q == S_FILL)   tcnt_q <= tcnt_q + TW'(1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign abort          = 1'b0;
`endif

  always_comb begin
    state_n     = state_q;
    issued_n    = issued_q;
    received_n  = received_q;
    req_valid_n = 1'b0;
    start       = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          start       = 1'b1;
          state_n     = S_FILL;
          issued_n    = '0;
          received_n  = '0;
          req_valid_n = 1'b1;
        end
      end
      S_FILL: begin
        issued_n    = issued_q + CW'(accept);
        received_n  = received_q + CW'(rsp_take);
        // An accept this cycle already counts toward the outstanding limit.
        req_valid_n = (issued_n < CW'(W)) && ((issued_n - received_n) < CW'(MAX_OUTSTANDING));
        if (rsp_take && (received_n == CW'(W))) begin
          done        = 1'b1;
          state_n     = S_IDLE;
          req_valid_n = 1'b0;
        end else if (abort) begin
          state_n     = S_IDLE;
          req_valid_n = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign req_addr_n = (start ? start_base : base_q) + (ADDR_WIDTH'(issued_n) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      base_q            <= '0;
      issued_q          <= '0;
      received_q        <= '0;
      line_q            <= '0;
      mem_rvalid        <= 1'b0;
      refill_err        <= 1'b0;
      bus.bus_req_valid <= 1'b0;
      bus.bus_req_addr  <= '0;
    end else begin
      state_q           <= state_n;
      issued_q          <= issued_n;
      received_q        <= received_n;
      bus.bus_req_valid <= req_valid_n;
      bus.bus_req_addr  <= req_addr_n;
      mem_rvalid        <= done || abort;
      refill_err        <= abort;
      if (start) base_q <= start_base;
      if (rsp_take) line_q[received_q[CW-2:0]] <= bus.bus_rdata;
      // Words never returned before an abort read back as zero.
      if (abort) begin
        for (int k = 0; k < W; k++) begin
          if (CW'(k) >= received_q) line_q[k] <= '0;
        end
      end
    end
  end

  assign mem_rdata = line_q;
  assign dbg_state = state_q;

endmodule
